// File: rtl/gshare_update_scheduler_if.sv
// ----------------------------------------------------------------------------
// gshare_update_scheduler_if
//   Bundles the fetch, execute and GShare-facing signals of the update
//   scheduler.
//   slave  : scheduler side (receives fetch/execute requests, drives GShare)
//   master : environment side (fetch unit, branch unit, GShare model)
// Signals
//   fe_valid/fe_pc -> fe_ready/fe_taken     prediction request / result
//   ex_valid/ex_taken -> ex_ready           branch resolution
//   mispredict, resolve_err                 registered status pulses
//   gs_predict/gs_predictPc <- gs_prediction  GShare predict port
//   gs_update/gs_updatePc/gs_reality          GShare update port
// ----------------------------------------------------------------------------
interface gshare_update_scheduler_if;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic        fe_ready;
   logic        fe_taken;
   logic        ex_valid;
   logic        ex_taken;
   logic        ex_ready;
   logic        mispredict;
   logic        resolve_err;
   logic        gs_predict;
   logic [31:0] gs_predictPc;
   logic        gs_prediction;
   logic        gs_update;
   logic [31:0] gs_updatePc;
   logic        gs_reality;

   modport slave (
      input  fe_valid, fe_pc, ex_valid, ex_taken, gs_prediction,
      output fe_ready, fe_taken, ex_ready, mispredict, resolve_err,
             gs_predict, gs_predictPc, gs_update, gs_updatePc, gs_reality
   );

   modport master (
      output fe_valid, fe_pc, ex_valid, ex_taken, gs_prediction,
      input  fe_ready, fe_taken, ex_ready, mispredict, resolve_err,
             gs_predict, gs_predictPc, gs_update, gs_updatePc, gs_reality
   );
endinterface

// File: rtl/gshare_update_scheduler.sv
// ----------------------------------------------------------------------------
// gshare_update_scheduler
//   Shares a single-ported GShare table between fetch-side predictions and
//   execute-side updates. Predicted branches are kept in order in an
//   in-flight queue (IFQ); each resolution pops the IFQ head and pushes the
//   resolved {pc, outcome} into an update buffer (UBUF) that is drained into
//   the predictor whenever the port is free, or forcibly after an update has
//   lost to predictions for STARVE_MAX consecutive cycles (or UBUF is full).
//   A wrong resolution flushes the IFQ; the UBUF is never flushed.
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   bus          gshare_update_scheduler_if.slave (fetch/execute/GShare)
//   stat_*       saturating event counters (only with SCHED_STATS_EN)
// Configuration
//   SCHED_STATS_EN  adds stat_pred/stat_upd/stat_mis counters and ports
// ----------------------------------------------------------------------------
module gshare_update_scheduler #(
   parameter int IFQ_DEPTH  = 8,
   parameter int UBUF_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   gshare_update_scheduler_if.slave       bus
`ifdef SCHED_STATS_EN
   ,
   output logic [31:0]                    stat_pred,
   output logic [31:0]                    stat_upd,
   output logic [31:0]                    stat_mis
`endif
);

   localparam int IA = $clog2(IFQ_DEPTH);
   localparam int UA = $clog2(UBUF_DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [IA:0] IFQ_ONE = 1;
   localparam logic [UA:0] UB_ONE  = 1;

   typedef enum logic {GRANT_PRED, FORCE_UPD} state_t;

   // queues: pointers carry one extra wrap bit for full/empty detection
   logic [31:0]    r_ifq_pc   [IFQ_DEPTH];
   logic           r_ifq_pred [IFQ_DEPTH];
   logic [IA:0]    r_ifq_wp, r_ifq_rp;
   logic [31:0]    r_ub_pc    [UBUF_DEPTH];
   logic           r_ub_real  [UBUF_DEPTH];
   logic [UA:0]    r_ub_wp, r_ub_rp;

   state_t         r_state, w_state_nxt;
   logic [SW-1:0]  r_starve, w_starve_nxt;
   logic           r_mis, r_rerr;

   logic           w_ifq_empty, w_ifq_full, w_ub_empty, w_ub_full;
   logic [31:0]    w_head_pc;
   logic           w_head_pred;
   logic           w_ex_ready, w_res_acc, w_flush;
   logic           w_fe_ready, w_pred_acc, w_drain;

   assign w_ifq_empty = (r_ifq_wp == r_ifq_rp);
   assign w_ifq_full  = (r_ifq_wp[IA] != r_ifq_rp[IA]) &&
                        (r_ifq_wp[IA-1:0] == r_ifq_rp[IA-1:0]);
   assign w_ub_empty  = (r_ub_wp == r_ub_rp);
   assign w_ub_full   = (r_ub_wp[UA] != r_ub_rp[UA]) &&
                        (r_ub_wp[UA-1:0] == r_ub_rp[UA-1:0]);

   assign w_head_pc   = r_ifq_pc[r_ifq_rp[IA-1:0]];
   assign w_head_pred = r_ifq_pred[r_ifq_rp[IA-1:0]];

   // Strobes are gated by reset so that asserting reset mid-cycle silences
   // the GShare port immediately, even while fetch keeps fe_valid high.
   assign w_ex_ready  = ~w_ub_full;
   assign w_res_acc   = ~reset & bus.ex_valid & w_ex_ready & ~w_ifq_empty;
   assign w_flush     = w_res_acc & (bus.ex_taken != w_head_pred);
   assign w_fe_ready  = (r_state == GRANT_PRED) & ~w_ifq_full & ~w_flush;
   assign w_pred_acc  = ~reset & bus.fe_valid & w_fe_ready;

   // Grant FSM: predict owns the port in GRANT_PRED; starve counts the
   // consecutive cycles a pending update was locked out by a prediction.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_drain      = 1'b0;
      case (r_state)
         GRANT_PRED: begin
            if (w_pred_acc) begin
               if (!w_ub_empty) begin
                  w_starve_nxt = (r_starve == SW'(STARVE_MAX)) ? r_starve
                                                               : r_starve + SW'(1);
                  if ((w_starve_nxt == SW'(STARVE_MAX)) || w_ub_full)
                     w_state_nxt = FORCE_UPD;
               end else begin
                  w_starve_nxt = '0;
               end
            end else begin
               w_starve_nxt = '0;
               w_drain      = ~w_ub_empty;
            end
         end
         FORCE_UPD: begin
            // UBUF may be empty here only if nothing remained; no op then
            w_drain      = ~w_ub_empty;
            w_starve_nxt = '0;
            w_state_nxt  = GRANT_PRED;
         end
         default: begin
            w_state_nxt  = GRANT_PRED;
            w_starve_nxt = '0;
         end
      endcase
      if (reset)
         w_drain = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= GRANT_PRED;
         r_starve <= '0;
         r_ifq_wp <= '0;
         r_ifq_rp <= '0;
         r_ub_wp  <= '0;
         r_ub_rp  <= '0;
         r_mis    <= 1'b0;
         r_rerr   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
         // flush empties the IFQ; fe_ready is 0 then, so nothing is pushed
         if (w_flush) begin
            r_ifq_rp <= r_ifq_wp;
         end else begin
            if (w_pred_acc) r_ifq_wp <= r_ifq_wp + IFQ_ONE;
            if (w_res_acc)  r_ifq_rp <= r_ifq_rp + IFQ_ONE;
         end
         if (w_res_acc) r_ub_wp <= r_ub_wp + UB_ONE;
         if (w_drain)   r_ub_rp <= r_ub_rp + UB_ONE;
         r_mis    <= w_flush;
         r_rerr   <= bus.ex_valid & w_ifq_empty;
      end
   end

   // queue storage needs no reset: pointers alone define validity
   always_ff @(posedge clk) begin
      if (w_pred_acc) begin
         r_ifq_pc[r_ifq_wp[IA-1:0]]   <= bus.fe_pc;
         r_ifq_pred[r_ifq_wp[IA-1:0]] <= bus.gs_prediction;
      end
      if (w_res_acc) begin
         r_ub_pc[r_ub_wp[UA-1:0]]   <= w_head_pc;
         r_ub_real[r_ub_wp[UA-1:0]] <= bus.ex_taken;
      end
   end

   assign bus.fe_ready     = w_fe_ready;
   assign bus.fe_taken     = w_pred_acc & bus.gs_prediction;
   assign bus.ex_ready     = w_ex_ready;
   assign bus.mispredict   = r_mis;
   assign bus.resolve_err  = r_rerr;
   assign bus.gs_predict   = w_pred_acc;
   assign bus.gs_predictPc = w_pred_acc ? bus.fe_pc : 32'd0;
   assign bus.gs_update    = w_drain;
   assign bus.gs_updatePc  = w_drain ? r_ub_pc[r_ub_rp[UA-1:0]] : 32'd0;
   assign bus.gs_reality   = w_drain & r_ub_real[r_ub_rp[UA-1:0]];

`ifdef SCHED_STATS_EN
   logic [31:0] r_stat_pred, r_stat_upd, r_stat_mis;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_pred <= '0;
         r_stat_upd  <= '0;
         r_stat_mis  <= '0;
      end else begin
         if (w_pred_acc && (r_stat_pred != 32'hFFFFFFFF)) r_stat_pred <= r_stat_pred + 32'd1;
         if (w_drain    && (r_stat_upd  != 32'hFFFFFFFF)) r_stat_upd  <= r_stat_upd  + 32'd1;
         if (w_flush    && (r_stat_mis  != 32'hFFFFFFFF)) r_stat_mis  <= r_stat_mis  + 32'd1;
      end
   end

   assign stat_pred = r_stat_pred;
   assign stat_upd  = r_stat_upd;
   assign stat_mis  = r_stat_mis;
`endif

endmodule

// File: tb/tb_gshare_update_scheduler.sv
module tb_gshare_update_scheduler;

   localparam int IFQ_DEPTH  = 8;
   localparam int UBUF_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic        b;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   // reference model: predicted-branch queue and expected update stream
   ent_t ifq_m[$];
   ent_t ub_m[$];
   logic exp_mis = 1'b0;
   logic exp_err = 1'b0;

   gshare_update_scheduler_if bus();

   gshare_update_scheduler #(
      .IFQ_DEPTH (IFQ_DEPTH),
      .UBUF_DEPTH(UBUF_DEPTH),
      .STARVE_MAX(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // scoreboard monitor: samples on the falling edge, inputs are stable then
   always @(negedge clk) begin
      int   ub_sz;
      logic pacc;
      ent_t e;
      if (reset) begin
         ifq_m.delete();
         ub_m.delete();
         exp_mis = 1'b0;
         exp_err = 1'b0;
         checks++;
         if ({bus.gs_predict, bus.gs_update, bus.mispredict, bus.resolve_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got pred=%b upd=%b mis=%b err=%b exp all 0",
                     bus.gs_predict, bus.gs_update, bus.mispredict, bus.resolve_err);
         end
      end else begin
         ub_sz = ub_m.size();
         checks++;
         if (bus.mispredict !== exp_mis) begin
            errors++;
            $display("FAIL mon_mispredict got=%b exp=%b", bus.mispredict, exp_mis);
         end
         checks++;
         if (bus.resolve_err !== exp_err) begin
            errors++;
            $display("FAIL mon_resolve_err got=%b exp=%b", bus.resolve_err, exp_err);
         end
         checks++;
         if (bus.gs_predict && bus.gs_update) begin
            errors++;
            $display("FAIL mon_one_op got pred=1 upd=1 exp at most one");
         end
         if (bus.gs_update) begin
            checks++;
            if (ub_m.size() == 0) begin
               errors++;
               $display("FAIL mon_update got pc=%0d with nothing pending", bus.gs_updatePc);
            end else begin
               e = ub_m.pop_front();
               if (bus.gs_updatePc !== e.pc || bus.gs_reality !== e.b) begin
                  errors++;
                  $display("FAIL mon_update got pc=%0d real=%b exp pc=%0d real=%b",
                           bus.gs_updatePc, bus.gs_reality, e.pc, e.b);
               end
            end
         end
         checks++;
         if (bus.ex_ready !== (ub_sz < UBUF_DEPTH)) begin
            errors++;
            $display("FAIL mon_ex_ready got=%b exp=%b", bus.ex_ready, ub_sz < UBUF_DEPTH);
         end
         pacc = bus.fe_valid & bus.fe_ready;
         checks++;
         if (bus.gs_predict !== pacc ||
             (pacc && (bus.gs_predictPc !== bus.fe_pc || bus.fe_taken !== bus.gs_prediction))) begin
            errors++;
            $display("FAIL mon_predict got strobe=%b pc=%0d taken=%b exp strobe=%b pc=%0d taken=%b",
                     bus.gs_predict, bus.gs_predictPc, bus.fe_taken, pacc, bus.fe_pc, bus.gs_prediction);
         end
         exp_err = bus.ex_valid & (ifq_m.size() == 0);
         exp_mis = 1'b0;
         if (bus.ex_valid && bus.ex_ready && ifq_m.size() > 0) begin
            e = ifq_m.pop_front();
            ub_m.push_back('{pc: e.pc, b: bus.ex_taken});
            if (e.b != bus.ex_taken) begin
               exp_mis = 1'b1;
               ifq_m.delete();
               checks++;
               if (bus.fe_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL mon_flush_fe_ready got=%b exp=0", bus.fe_ready);
               end
            end
         end
         if (pacc && !exp_mis)
            ifq_m.push_back('{pc: bus.fe_pc, b: bus.gs_prediction});
      end
   end

   task automatic drive(input logic fv, input logic [31:0] pc, input logic gp,
                        input logic xv, input logic xt);
      @(posedge clk);
      #1;
      bus.fe_valid      = fv;
      bus.fe_pc         = pc;
      bus.gs_prediction = gp;
      bus.ex_valid      = xv;
      bus.ex_taken      = xt;
   endtask

   // resolve everything in flight correctly, then let the UBUF drain
   task automatic drain_all();
      for (int i = 0; i < 40 && ifq_m.size() > 0; i++) begin
         drive(1'b0, 32'd0, 1'b0, 1'b1, ifq_m[0].b);
         @(negedge clk);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if (ifq_m.size() != 0 || ub_m.size() != 0) begin
         errors++;
         $display("FAIL drain_all got ifq=%0d ubuf=%0d pending exp 0 0", ifq_m.size(), ub_m.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b1 || bus.ex_ready !== 1'b1 || bus.fe_taken !== 1'b0 ||
          bus.gs_predictPc !== 32'd0 || bus.gs_updatePc !== 32'd0 || bus.gs_reality !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got fe_ready=%b ex_ready=%b fe_taken=%b ppc=%0d upc=%0d real=%b exp 1 1 0 0 0 0",
                  bus.fe_ready, bus.ex_ready, bus.fe_taken, bus.gs_predictPc, bus.gs_updatePc, bus.gs_reality);
      end
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic test_predict_resolve();
      drive(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b1 || bus.gs_predict !== 1'b1 || bus.fe_taken !== 1'b0) begin
         errors++;
         $display("FAIL t1_predict got ready=%b strobe=%b taken=%b exp 1 1 0", bus.fe_ready, bus.gs_predict, bus.fe_taken);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.gs_update !== 1'b0) begin
         errors++;
         $display("FAIL t1_no_early_update got=%b exp=0", bus.gs_update);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.gs_update !== 1'b1 || bus.gs_updatePc !== 32'd1 || bus.gs_reality !== 1'b0 || bus.mispredict !== 1'b0) begin
         errors++;
         $display("FAIL t1_update got upd=%b pc=%0d real=%b mis=%b exp 1 1 0 0",
                  bus.gs_update, bus.gs_updatePc, bus.gs_reality, bus.mispredict);
      end
      drain_all();
   endtask

   task automatic test_mispredict_flush();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b0 || bus.mispredict !== 1'b0) begin
         errors++;
         $display("FAIL t2_flush_cycle got ready=%b mis=%b exp 0 0", bus.fe_ready, bus.mispredict);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.mispredict !== 1'b1 || bus.gs_update !== 1'b1 || bus.gs_updatePc !== 32'd1 || bus.gs_reality !== 1'b1) begin
         errors++;
         $display("FAIL t2_mispredict got mis=%b upd=%b pc=%0d real=%b exp 1 1 1 1",
                  bus.mispredict, bus.gs_update, bus.gs_updatePc, bus.gs_reality);
      end
      @(negedge clk);
      checks++;
      if (bus.mispredict !== 1'b0 || bus.gs_update !== 1'b0) begin
         errors++;
         $display("FAIL t2_after got mis=%b upd=%b exp 0 0", bus.mispredict, bus.gs_update);
      end
      // the flushed pc=2,3 must not be resolvable any more
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.resolve_err !== 1'b1) begin
         errors++;
         $display("FAIL t2_ifq_empty got resolve_err=%b exp=1", bus.resolve_err);
      end
      drain_all();
   endtask

   // cycles 1..5 hold fe_valid; cycle 2 resolves pc=10 so one update waits
   task automatic starve_setup();
      drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'd11, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(12 + i), 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         checks++;
         if (bus.fe_ready !== 1'b1 || bus.gs_update !== 1'b0) begin
            errors++;
            $display("FAIL t3_wait%0d got ready=%b upd=%b exp 1 0", i, bus.fe_ready, bus.gs_update);
         end
      end
      drive(1'b1, 32'd15, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b0 || bus.gs_update !== 1'b1 || bus.gs_updatePc !== 32'd10) begin
         errors++;
         $display("FAIL t3_forced got ready=%b upd=%b pc=%0d exp 0 1 10", bus.fe_ready, bus.gs_update, bus.gs_updatePc);
      end
   endtask

   task automatic test_starve();
      starve_setup();
      drive(1'b1, 32'd16, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b1 || bus.gs_predict !== 1'b1) begin
         errors++;
         $display("FAIL t3_release got ready=%b pred=%b exp 1 1", bus.fe_ready, bus.gs_predict);
      end
      drain_all();
   endtask

   task automatic test_ifq_full();
      for (int i = 0; i < IFQ_DEPTH; i++) begin
         drive(1'b1, 32'(40 + i), i[0], 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b0 || bus.gs_predict !== 1'b0) begin
         errors++;
         $display("FAIL t4_full got ready=%b pred=%b exp 0 0", bus.fe_ready, bus.gs_predict);
      end
      drive(1'b1, 32'd101, 1'b0, 1'b1, ifq_m[0].b);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b0) begin
         errors++;
         $display("FAIL t4_resolve_cycle got ready=%b exp=0", bus.fe_ready);
      end
      drive(1'b1, 32'd102, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.fe_ready !== 1'b1 || bus.fe_taken !== 1'b1) begin
         errors++;
         $display("FAIL t4_reopen got ready=%b taken=%b exp 1 1", bus.fe_ready, bus.fe_taken);
      end
      drain_all();
   endtask

   task automatic test_resolve_empty();
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.gs_update !== 1'b0 || bus.ex_ready !== 1'b1 || bus.resolve_err !== 1'b0) begin
         errors++;
         $display("FAIL t5_req got upd=%b ready=%b err=%b exp 0 1 0", bus.gs_update, bus.ex_ready, bus.resolve_err);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.resolve_err !== 1'b1 || bus.gs_update !== 1'b0) begin
         errors++;
         $display("FAIL t5_err got err=%b upd=%b exp 1 0", bus.resolve_err, bus.gs_update);
      end
      @(negedge clk);
      checks++;
      if (bus.resolve_err !== 1'b0 || bus.gs_update !== 1'b0) begin
         errors++;
         $display("FAIL t5_pulse got err=%b upd=%b exp 0 0", bus.resolve_err, bus.gs_update);
      end
   endtask

   task automatic test_random();
      logic xt;
      for (int i = 0; i < 300; i++) begin
         xt = (ifq_m.size() > 0 && $urandom_range(0, 3) != 0) ? ifq_m[0].b : 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), xt);
         @(negedge clk);
      end
      drain_all();
   endtask

   task automatic test_reset_force();
      starve_setup();
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.gs_update !== 1'b0 || bus.gs_predict !== 1'b0 || bus.fe_ready !== 1'b1 || bus.ex_ready !== 1'b1) begin
         errors++;
         $display("FAIL t6_reset_now got upd=%b pred=%b fe_ready=%b ex_ready=%b exp 0 0 1 1",
                  bus.gs_update, bus.gs_predict, bus.fe_ready, bus.ex_ready);
      end
      bus.fe_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.resolve_err !== 1'b1) begin
         errors++;
         $display("FAIL t6_ifq_empty got resolve_err=%b exp=1", bus.resolve_err);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.gs_update !== 1'b0) begin
            errors++;
            $display("FAIL t6_ubuf_empty cycle %0d got gs_update=%b exp=0", i, bus.gs_update);
         end
      end
   endtask

   initial begin
      bus.fe_valid      = 1'b0;
      bus.fe_pc         = 32'd0;
      bus.gs_prediction = 1'b0;
      bus.ex_valid      = 1'b0;
      bus.ex_taken      = 1'b0;
      test_reset();
      test_predict_resolve();
      test_mispredict_flush();
      test_starve();
      test_ifq_full();
      test_resolve_empty();
      test_random();
      test_reset_force();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
